// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and constants for the multicycle control unit: state encoding,
// opcode/condition/ALU command codes, datapath mux selects and flag bit indices.
package multicycle_ctrl_fsm_pkg;

   localparam int unsigned FLAG_W  = 4;
   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   // flag vector bit positions {N,Z,C,V}
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_UND = 2'b11;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;

   localparam logic [1:0] SRCA_RD1    = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction-field / datapath-control bundle between the multicycle datapath
// (master: drives IR fields and ALU flags) and the control unit (slave: drives
// mux selects and write enables).
interface multicycle_ctrl_fsm_if;

   logic [3:0]                                 Cond;
   logic [1:0]                                 Op;
   logic [5:0]                                 Funct;
   logic [3:0]                                 Rd;
   logic [multicycle_ctrl_fsm_pkg::FLAG_W-1:0] ALUFlags;

   logic       PCWrite;
   logic       MemWrite;
   logic       RegWrite;
   logic       IRWrite;
   logic       AdrSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic [1:0] ImmSrc;
   logic [1:0] RegSrc;
   logic [1:0] ALUControl;

   modport master (
      output Cond, Op, Funct, Rd, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
   );

   modport slave (
      input  Cond, Op, Funct, Rd, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc,
             ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
   );

endinterface

// File: rtl/multicycle_ctrl_fsm_cond_eval.sv
// Condition evaluator: decides whether an instruction's condition field passes
// against the current {N,Z,C,V} flags.
//   cond   in  4       condition field
//   flags  in  FLAG_W  stored flag register
//   condex out 1       condition passed
module multicycle_ctrl_fsm_cond_eval
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] flags,
   output logic              condex
);

   logic n, z, c, v;

   assign n = flags[FLAG_N];
   assign z = flags[FLAG_Z];
   assign c = flags[FLAG_C];
   assign v = flags[FLAG_V];

   always_comb begin
      condex = 1'b0;
      case (cond)
         COND_EQ: condex = z;
         COND_NE: condex = ~z;
         COND_CS: condex = c;
         COND_CC: condex = ~c;
         COND_MI: condex = n;
         COND_PL: condex = ~n;
         COND_VS: condex = v;
         COND_VC: condex = ~v;
         COND_HI: condex = c & ~z;
         COND_LS: condex = ~c | z;
         COND_GE: condex = (n == v);
         COND_LT: condex = (n != v);
         COND_GT: condex = ~z & (n == v);
         COND_LE: condex = z | (n != v);
         COND_AL: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control unit: Moore FSM sequencing the shared datapath, ALU
// decoder, NZCV flag register and condition gating of architectural writes.
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   bus       slave IR fields / ALU flags in, mux selects / enables out
//   state_dbg out  current state encoding
module multicycle_ctrl_fsm
   import multicycle_ctrl_fsm_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_fsm_if.slave  bus,
   output logic [STATE_W-1:0]    state_dbg
);

   state_t            state_q, state_d;
   logic [FLAG_W-1:0] flags_q;
   logic              condex_q;
   logic              nowrite_q;
   logic              cond_ok;

   logic       next_pc, reg_w, mem_w, branch, alu_op, ir_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src;
   logic [1:0] alu_control, flag_w;
   logic       no_write, s_eff;
   logic       exec_state, pcs;

   multicycle_ctrl_fsm_cond_eval u_cond (
      .cond   (bus.Cond),
      .flags  (flags_q),
      .condex (cond_ok)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // next state and Moore controls
   always_comb begin
      state_d    = state_q;
      next_pc    = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      alu_op     = 1'b0;
      ir_write   = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_RD1;
      alu_src_b  = SRCB_RD2;
      result_src = RES_ALUOUT;
      case (state_q)
         S_FETCH: begin
            ir_write   = 1'b1;
            next_pc    = 1'b1;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            state_d    = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            result_src = RES_ALU;
            case (bus.Op)
               OP_MEM:  state_d = S_MEMADR;
               OP_DP:   state_d = bus.Funct[5] ? S_EXECI : S_EXECR;
               OP_BR:   state_d = S_BRANCH;
               OP_UND:  state_d = S_FETCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alu_src_b = SRCB_IMM;
            state_d   = bus.Funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_w      = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            state_d = S_FETCH;
         end
         S_EXECR: begin
            alu_op  = 1'b1;
            state_d = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_b = SRCB_IMM;
            alu_op    = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_w      = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_ALUOUT;
            alu_src_b  = SRCB_IMM;
            result_src = RES_ALU;
            branch     = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // ALU decoder; CMP forces S, unsupported commands write nothing
   always_comb begin
      alu_control = ALU_ADD;
      flag_w      = 2'b00;
      no_write    = 1'b0;
      s_eff       = 1'b0;
      if (alu_op) begin
         s_eff = bus.Funct[0];
         case (bus.Funct[4:1])
            CMD_ADD: alu_control = ALU_ADD;
            CMD_SUB: alu_control = ALU_SUB;
            CMD_AND: alu_control = ALU_AND;
            CMD_ORR: alu_control = ALU_ORR;
            CMD_CMP: begin
               alu_control = ALU_SUB;
               no_write    = 1'b1;
               s_eff       = 1'b1;
            end
            default: begin
               alu_control = ALU_ADD;
               no_write    = 1'b1;
               s_eff       = 1'b0;
            end
         endcase
         if (s_eff) flag_w = {1'b1, (alu_control == ALU_ADD) || (alu_control == ALU_SUB)};
      end
   end

   assign exec_state = (state_q == S_EXECR) || (state_q == S_EXECI);

   // condition result latched at end of DECODE; NoWrite carried from EXEC
   // into ALUWB since the decoder only reports it while ALUOp is set
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         condex_q  <= 1'b0;
         nowrite_q <= 1'b0;
      end else begin
         if (state_q == S_DECODE) begin
            condex_q  <= cond_ok;
            nowrite_q <= 1'b0;
         end
         if (exec_state) nowrite_q <= no_write;
      end
   end

   // NZCV register, split N/Z and C/V write enables
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q <= '0;
      end else if (exec_state && condex_q) begin
         if (flag_w[1]) flags_q[FLAG_N:FLAG_Z] <= bus.ALUFlags[FLAG_N:FLAG_Z];
         if (flag_w[0]) flags_q[FLAG_C:FLAG_V] <= bus.ALUFlags[FLAG_C:FLAG_V];
      end
   end

   assign pcs = branch | (reg_w & (bus.Rd == 4'hF));

   // write enables held low for the whole reset assertion
   assign bus.PCWrite    = ~reset & (next_pc | (pcs & condex_q));
   assign bus.RegWrite   = ~reset & reg_w & condex_q & ~nowrite_q;
   assign bus.MemWrite   = ~reset & mem_w & condex_q;
   assign bus.IRWrite    = ~reset & ir_write;
   assign bus.AdrSrc     = adr_src;
   assign bus.ALUSrcA    = alu_src_a;
   assign bus.ALUSrcB    = alu_src_b;
   assign bus.ResultSrc  = result_src;
   assign bus.ALUControl = alu_control;
   assign bus.ImmSrc     = bus.Op;
   assign bus.RegSrc     = {bus.Op == OP_MEM, bus.Op == OP_BR};
   assign state_dbg      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for the multicycle control unit: per-cycle expected control
// vectors are queued when an instruction is driven and compared as it executes.
module tb_multicycle_ctrl_fsm;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       memw;
      logic       regw;
      logic       irw;
      logic       adr;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] res;
      logic [1:0] alu;
      logic [1:0] imm;
      logic [1:0] rsrc;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] state_dbg;
   logic [3:0] mflags;
   int         ncmp  = 0;
   int         nfail = 0;
   exp_t       sb[$];
   string      tags[$];

   multicycle_ctrl_fsm_if bus ();

   multicycle_ctrl_fsm dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t observed();
      exp_t o;
      o.st   = state_dbg;
      o.pcw  = bus.PCWrite;
      o.memw = bus.MemWrite;
      o.regw = bus.RegWrite;
      o.irw  = bus.IRWrite;
      o.adr  = bus.AdrSrc;
      o.a    = bus.ALUSrcA;
      o.b    = bus.ALUSrcB;
      o.res  = bus.ResultSrc;
      o.alu  = bus.ALUControl;
      o.imm  = bus.ImmSrc;
      o.rsrc = bus.RegSrc;
      return o;
   endfunction

   // independent reference of the condition table
   function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cc, v;
      {n, z, cc, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc && !z;
         4'h9: return !cc || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // {alu_control, reg write allowed, flag_w[1], flag_w[0]} for a DP command
   function automatic logic [4:0] alu_model(input logic [3:0] cmd, input logic s);
      case (cmd)
         4'b0100: return {2'b00, 1'b1, s, s};
         4'b0010: return {2'b01, 1'b1, s, s};
         4'b0000: return {2'b10, 1'b1, s, 1'b0};
         4'b1100: return {2'b11, 1'b1, s, 1'b0};
         4'b1010: return {2'b01, 1'b0, 1'b1, 1'b1};
         default: return {2'b00, 1'b0, 1'b0, 1'b0};
      endcase
   endfunction

   task automatic push(input exp_t e, input string tag);
      sb.push_back(e);
      tags.push_back(tag);
   endtask

   // Entered just after a negedge with the DUT in FETCH; returns likewise.
   task automatic do_instr(input string name, input logic [3:0] c, input logic [1:0] op,
                           input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af);
      logic       ok;
      logic [4:0] am;
      exp_t       base, e;
      string      tag;
      int         n;
      ok = cond_model(c, mflags);
      am = alu_model(f[4:1], f[0]);
      bus.Cond = c; bus.Op = op; bus.Funct = f; bus.Rd = rd; bus.ALUFlags = af;
      base = '0;
      base.imm  = op;
      base.rsrc = {op == 2'b01, op == 2'b10};
      e = base; e.st = 4'd0; e.pcw = 1'b1; e.irw = 1'b1; e.a = 2'b01; e.b = 2'b10; e.res = 2'b10;
      push(e, {name, ".fetch"});
      e = base; e.st = 4'd1; e.a = 2'b01; e.b = 2'b10; e.res = 2'b10;
      push(e, {name, ".decode"});
      case (op)
         2'b01: begin
            e = base; e.st = 4'd2; e.b = 2'b01;
            push(e, {name, ".memadr"});
            if (f[0]) begin
               e = base; e.st = 4'd3; e.adr = 1'b1;
               push(e, {name, ".memrd"});
               e = base; e.st = 4'd4; e.res = 2'b01; e.regw = ok; e.pcw = ok && (rd == 4'hF);
               push(e, {name, ".memwb"});
            end else begin
               e = base; e.st = 4'd5; e.adr = 1'b1; e.memw = ok;
               push(e, {name, ".memwr"});
            end
         end
         2'b00: begin
            e = base; e.st = f[5] ? 4'd7 : 4'd6; e.b = f[5] ? 2'b01 : 2'b00; e.alu = am[4:3];
            push(e, {name, ".exec"});
            e = base; e.st = 4'd8; e.regw = ok && am[2]; e.pcw = ok && (rd == 4'hF);
            push(e, {name, ".aluwb"});
            if (ok && am[1]) mflags[3:2] = af[3:2];
            if (ok && am[0]) mflags[1:0] = af[1:0];
         end
         2'b10: begin
            e = base; e.st = 4'd9; e.a = 2'b10; e.b = 2'b01; e.res = 2'b10; e.pcw = ok;
            push(e, {name, ".branch"});
         end
         default: ;
      endcase
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         if (i == 0) #1;
         else        @(negedge clk);
         e   = sb.pop_front();
         tag = tags.pop_front();
         chk(tag, 32'(observed()), 32'(e));
      end
      @(negedge clk);
      chk({name, ".flags"}, 32'(dut.flags_q), 32'(mflags));
   endtask

   initial begin
      reset = 1'b1;
      mflags = 4'h0;
      bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'h0;
      repeat (2) @(negedge clk);
      chk("reset.state", 32'(state_dbg), 32'd0);
      chk("reset.writes", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
      chk("reset.flags", 32'(dut.flags_q), 32'd0);
      reset = 1'b0;

      do_instr("adds",    4'hE, 2'b00, 6'b001001, 4'h1, 4'b0110);
      do_instr("cmp_eq",  4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
      do_instr("beq_t",   4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000);
      do_instr("cmp_ne",  4'hE, 2'b00, 6'b010101, 4'h0, 4'b0000);
      do_instr("beq_nt",  4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000);
      do_instr("cmp_z",   4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
      do_instr("ldrne_f", 4'h1, 2'b01, 6'b011001, 4'h2, 4'b0000);
      do_instr("cmp_nz",  4'hE, 2'b00, 6'b010101, 4'h0, 4'b0000);
      do_instr("ldrne_t", 4'h1, 2'b01, 6'b011001, 4'h2, 4'b0000);
      do_instr("str",     4'hE, 2'b01, 6'b011000, 4'h3, 4'b0000);
      do_instr("add_pc",  4'hE, 2'b00, 6'b101000, 4'hF, 4'b1111);
      do_instr("undef",   4'hE, 2'b11, 6'b111111, 4'hF, 4'b1111);
      do_instr("orrs",    4'hE, 2'b00, 6'b111001, 4'h4, 4'b1111);
      do_instr("eors",    4'hE, 2'b00, 6'b000011, 4'h5, 4'b0011);
      do_instr("never",   4'hF, 2'b00, 6'b001001, 4'h6, 4'b0011);

      // reset landing in the middle of a store
      bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011000; bus.Rd = 4'h3; bus.ALUFlags = 4'h0;
      repeat (3) @(negedge clk);
      chk("midrst.memwr_state", 32'(state_dbg), 32'd5);
      chk("midrst.memwrite_pre", 32'(bus.MemWrite), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst.memwrite", 32'(bus.MemWrite), 32'd0);
      chk("midrst.state", 32'(state_dbg), 32'd0);
      chk("midrst.pc_ir", 32'({bus.PCWrite, bus.IRWrite}), 32'd0);
      chk("midrst.flags", 32'(dut.flags_q), 32'd0);
      mflags = 4'h0;
      @(negedge clk);
      reset = 1'b0;

      do_instr("post_beq", 4'h0, 2'b10, 6'b000000, 4'h0, 4'b0000);
      do_instr("post_ldr", 4'hE, 2'b01, 6'b011001, 4'hF, 4'b0000);
      do_instr("post_sub", 4'hE, 2'b00, 6'b100101, 4'h7, 4'b1001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
